axi_lite_bram_ctrl: RTL and testbench

AXI4-Lite slave that masters one port of the MicroBlaze-side BRAM block, which is the initiator end of the BRAM_* port bundle.
- Converts single-beat AXI-Lite reads and writes into BRAM enable/write-enable/address/data cycles.
- Sits between the AXI interconnect and the BRAM block's port A or B.
- One outstanding transaction at a time.

---
 rtl/axi_lite_bram_ctrl_pkg.sv | 37 +++
 rtl/axi_lite_bram_ctrl_if.sv | 39 +++
 rtl/axi_lite_bram_ctrl.sv | 146 ++++++++++++++
 tb/tb_axi_lite_bram_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_bram_ctrl_pkg.sv
// Shared types for the AXI-Lite BRAM controller: FSM states, response codes, lane reversal.
// Latency: n/a (declarations only).  Backpressure: n/a.
// Optional round-robin arbitration is selected in the top by AXI_BRAM_CTRL_RR_ARB_EN.
package axi_bram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // BRAM side numbers bits from the MSB (bit 0 = MSB), AXI side from the LSB.
  function automatic logic [0:31] lane_rev32(input logic [31:0] v);
    logic [0:31] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  function automatic logic [31:0] lane_unrev32(input logic [0:31] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[31-i] = v[i];
    return r;
  endfunction

  function automatic logic [0:3] lane_rev4(input logic [3:0] v);
    logic [0:3] r;
    for (int k = 0; k < 4; k++) r[k] = v[3-k];
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_bram_ctrl_if.sv
// AXI4-Lite slave-facing bus bundle (five channels) with master/slave views.
// Latency: n/a (wires only).  Backpressure: standard VALID/READY on every channel.
// Used by axi_lite_bram_ctrl; AXI_BRAM_CTRL_RR_ARB_EN does not affect this bundle.
interface axi_lite_bram_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
           S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
           S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/axi_lite_bram_ctrl.sv
// AXI4-Lite slave mastering one BRAM port, one transaction outstanding.
// Latency: handshake to BVALID 2 cycles, handshake to RVALID 3 cycles (1-cycle BRAM read).
// Backpressure: AW+W taken together only from IDLE; B/R held until READY. AXI_BRAM_CTRL_RR_ARB_EN = round-robin W/R.
module axi_lite_bram_ctrl
  import axi_bram_ctrl_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR         = 32'h0000_0000,
  parameter logic [31:0] C_MEMSIZE          = 32'h0000_4000,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_PORT_DWIDTH      = 32,
  parameter int          C_PORT_AWIDTH      = 32,
  parameter int          C_NUM_WE           = 4
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  axi_lite_bram_ctrl_if.slave      s_axi,
  output logic                     BRAM_Clk,
  output logic                     BRAM_Rst,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

  localparam int          ADDR_LSB  = $clog2(C_MEMSIZE);
  localparam logic [31:0] OFFS_MASK = (C_MEMSIZE - 32'd1) & ~32'd3;

  state_t state_q, state_d;

  logic [31:0]                   addr_q;
  logic                          in_range_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [3:0]                    wstrb_q;
  logic [1:0]                    bresp_q;
  logic [1:0]                    rresp_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;

  logic                          wr_req, rd_req, grant_wr, grant_rd;
  logic [C_S_AXI_ADDR_WIDTH-1:0] addr_sel;
  logic                          in_range_sel;

  // Reset gates the request terms so READY never rises while ARESETN is low.
  assign wr_req = (state_q == IDLE) && S_AXI_ARESETN &&
                  s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
  assign rd_req = (state_q == IDLE) && S_AXI_ARESETN && s_axi.S_AXI_ARVALID;

`ifdef AXI_BRAM_CTRL_RR_ARB_EN
  logic last_wr_q;

  // On a tie the channel that did not win last time is granted.
  assign grant_wr = wr_req && (!rd_req || !last_wr_q);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      last_wr_q <= 1'b0;
    end else if (grant_wr) begin
      last_wr_q <= 1'b1;
    end else if (grant_rd) begin
      last_wr_q <= 1'b0;
    end
  end
`else
  assign grant_wr = wr_req;
`endif

  assign grant_rd = rd_req && !grant_wr;

  assign addr_sel     = grant_wr ? s_axi.S_AXI_AWADDR : s_axi.S_AXI_ARADDR;
  assign in_range_sel = (addr_sel[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB] ==
                         C_BASEADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB]);

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_wr) begin
          state_d = WR_ACC;
        end else if (grant_rd) begin
          state_d = RD_ADDR;
        end
      end
      WR_ACC:  state_d = WR_RESP;
      WR_RESP: if (s_axi.S_AXI_BREADY) state_d = IDLE;
      RD_ADDR: state_d = RD_DATA;
      RD_DATA: state_d = RD_RESP;
      RD_RESP: if (s_axi.S_AXI_RREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      addr_q     <= '0;
      in_range_q <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RESP_OKAY;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      if (grant_wr || grant_rd) begin
        addr_q     <= C_BASEADDR | (32'(addr_sel) & OFFS_MASK);
        in_range_q <= in_range_sel;
      end
      if (grant_wr) begin
        wdata_q <= s_axi.S_AXI_WDATA;
        wstrb_q <= s_axi.S_AXI_WSTRB;
        bresp_q <= in_range_sel ? RESP_OKAY : RESP_SLVERR;
      end
      if (grant_rd) begin
        rresp_q <= in_range_sel ? RESP_OKAY : RESP_SLVERR;
      end
      // BRAM data is valid one clock after the enable cycle.
      if (state_q == RD_DATA) begin
        rdata_q <= in_range_q ? lane_unrev32(BRAM_Din) : '0;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = grant_wr;
  assign s_axi.S_AXI_WREADY  = grant_wr;
  assign s_axi.S_AXI_ARREADY = grant_rd;
  assign s_axi.S_AXI_BVALID  = (state_q == WR_RESP);
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_RVALID  = (state_q == RD_RESP);
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;

  assign BRAM_Clk  = S_AXI_ACLK;
  assign BRAM_Rst  = ~S_AXI_ARESETN;
  assign BRAM_EN   = ((state_q == WR_ACC) || (state_q == RD_ADDR)) && in_range_q;
  assign BRAM_WEN  = ((state_q == WR_ACC) && in_range_q) ? lane_rev4(wstrb_q) : '0;
  assign BRAM_Addr = addr_q;
  assign BRAM_Dout = lane_rev32(wdata_q);

endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// Directed bench for axi_lite_bram_ctrl with a 1-cycle-latency BRAM model on the port.
// Expected arbitration order follows AXI_BRAM_CTRL_RR_ARB_EN when defined.
module tb_axi_lite_bram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bram_clk, bram_rst, bram_en;
  logic [0:3]  bram_wen;
  logic [0:31] bram_addr, bram_dout, bram_din;

  int pass_cnt  = 0;
  int total_cnt = 0;

  axi_lite_bram_ctrl_if s_axi ();

  axi_lite_bram_ctrl dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (s_axi),
    .BRAM_Clk      (bram_clk),
    .BRAM_Rst      (bram_rst),
    .BRAM_EN       (bram_en),
    .BRAM_WEN      (bram_wen),
    .BRAM_Addr     (bram_addr),
    .BRAM_Dout     (bram_dout),
    .BRAM_Din      (bram_din)
  );

  always #5 clk = ~clk;

  // Byte-enable model memory; read-first, data appears one clock after EN.
  logic [31:0] mem [0:4095];
  logic [31:0] din_q = 32'h0;
  logic [31:0] addr_v, dout_v;
  logic [3:0]  wen_v;

  assign addr_v   = bram_addr;
  assign dout_v   = bram_dout;
  assign wen_v    = bram_wen;
  assign bram_din = din_q;

  initial for (int i = 0; i < 4096; i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    if (bram_en) begin
      din_q <= mem[addr_v[13:2]];
      for (int j = 0; j < 4; j++)
        if (wen_v[j]) mem[addr_v[13:2]][8*j +: 8] <= dout_v[8*j +: 8];
    end
  end

  int          en_cnt = 0;
  logic [31:0] last_addr = 32'h0, last_dout = 32'h0;
  logic [3:0]  last_wen = 4'h0;

  always @(negedge clk) begin
    if (bram_en) begin
      en_cnt    = en_cnt + 1;
      last_addr = addr_v;
      last_dout = dout_v;
      last_wen  = wen_v;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Both tasks enter and leave 1 time unit after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic wait_b, output logic [1:0] resp, output int lat);
    int n = 0;
    s_axi.S_AXI_AWADDR  = a;
    s_axi.S_AXI_WDATA   = d;
    s_axi.S_AXI_WSTRB   = s;
    s_axi.S_AXI_AWVALID = 1'b1;
    s_axi.S_AXI_WVALID  = 1'b1;
    #1;
    while (!(s_axi.S_AXI_AWREADY && s_axi.S_AXI_WREADY) && n < 20) begin
      @(posedge clk); #2; n++;
    end
    @(posedge clk); #1;
    s_axi.S_AXI_AWVALID = 1'b0;
    s_axi.S_AXI_WVALID  = 1'b0;
    lat = 1;
    #1;
    while (!s_axi.S_AXI_BVALID && lat < 20) begin
      @(posedge clk); #2; lat++;
    end
    resp = s_axi.S_AXI_BRESP;
    if (wait_b) begin
      s_axi.S_AXI_BREADY = 1'b1;
      @(posedge clk); #1;
      s_axi.S_AXI_BREADY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n = 0;
    s_axi.S_AXI_ARADDR  = a;
    s_axi.S_AXI_ARVALID = 1'b1;
    #1;
    while (!s_axi.S_AXI_ARREADY && n < 20) begin
      @(posedge clk); #2; n++;
    end
    @(posedge clk); #1;
    s_axi.S_AXI_ARVALID = 1'b0;
    lat = 1;
    #1;
    while (!s_axi.S_AXI_RVALID && lat < 20) begin
      @(posedge clk); #2; lat++;
    end
    data = s_axi.S_AXI_RDATA;
    resp = s_axi.S_AXI_RRESP;
    s_axi.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    s_axi.S_AXI_RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [7:0]  order, order_exp;
    int          lat, en0, nw, nr;
    logic        gw, gr;

    s_axi.S_AXI_AWADDR  = '0; s_axi.S_AXI_AWVALID = 1'b0;
    s_axi.S_AXI_WDATA   = '0; s_axi.S_AXI_WSTRB   = '0; s_axi.S_AXI_WVALID = 1'b0;
    s_axi.S_AXI_BREADY  = 1'b0;
    s_axi.S_AXI_ARADDR  = '0; s_axi.S_AXI_ARVALID = 1'b0;
    s_axi.S_AXI_RREADY  = 1'b0;

    // Reset state
    #23;
    chk("rst_awready", 32'(s_axi.S_AXI_AWREADY), 32'h0);
    chk("rst_arready", 32'(s_axi.S_AXI_ARREADY), 32'h0);
    chk("rst_bvalid",  32'(s_axi.S_AXI_BVALID),  32'h0);
    chk("rst_rvalid",  32'(s_axi.S_AXI_RVALID),  32'h0);
    chk("rst_rdata",   s_axi.S_AXI_RDATA,        32'h0);
    chk("rst_bram_en", 32'(bram_en),             32'h0);
    chk("rst_bram_wen",32'(wen_v),               32'h0);
    chk("rst_bram_addr", addr_v,                 32'h0);
    chk("rst_bram_dout", dout_v,                 32'h0);
    chk("rst_bram_rst", 32'(bram_rst),           32'h1);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("run_bram_rst", 32'(bram_rst), 32'h0);

    // Full-word write then readback
    en0 = en_cnt;
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, resp, lat);
    chk("wr_latency",  32'(lat),      32'd2);
    chk("wr_bresp",    32'(resp),     32'h0);
    chk("wr_en_count", 32'(en_cnt - en0), 32'd1);
    chk("wr_wen",      32'(last_wen), 32'hF);
    chk("wr_addr",     last_addr,     32'h10);
    chk("wr_dout",     last_dout,     32'hDEAD_BEEF);

    en0 = en_cnt;
    axi_read(32'h10, rd, resp, lat);
    chk("rd_latency",  32'(lat),      32'd3);
    chk("rd_rdata",    rd,            32'hDEAD_BEEF);
    chk("rd_rresp",    32'(resp),     32'h0);
    chk("rd_en_count", 32'(en_cnt - en0), 32'd1);
    chk("rd_wen",      32'(last_wen), 32'h0);

    // Single low byte
    axi_write(32'h10, 32'h0000_00AA, 4'b0001, 1'b1, resp, lat);
    chk("byte_wen",   32'(last_wen), 32'h1);
    chk("byte_bresp", 32'(resp),     32'h0);
    axi_read(32'h10, rd, resp, lat);
    chk("byte_rdata", rd, 32'hDEAD_BEAA);

    // Unaligned read address drops the low two bits
    axi_read(32'h13, rd, resp, lat);
    chk("unal_addr",  last_addr, 32'h10);
    chk("unal_rdata", rd,        32'hDEAD_BEAA);

    // Top word of the window, upper two byte lanes
    axi_write(32'h3FFC, 32'h1234_5678, 4'b1100, 1'b1, resp, lat);
    chk("top_wen",  32'(last_wen), 32'hC);
    chk("top_addr", last_addr,     32'h3FFC);
    axi_read(32'h3FFC, rd, resp, lat);
    chk("top_rdata", rd, 32'h1234_0000);

    // Zero strobe: enable still pulses with no byte written
    en0 = en_cnt;
    axi_write(32'h10, 32'hFFFF_FFFF, 4'h0, 1'b1, resp, lat);
    chk("zstrb_en_count", 32'(en_cnt - en0), 32'd1);
    chk("zstrb_wen",      32'(last_wen),     32'h0);
    chk("zstrb_bresp",    32'(resp),         32'h0);

    // Just past the window
    en0 = en_cnt;
    axi_write(32'h4000, 32'h5555_5555, 4'hF, 1'b1, resp, lat);
    chk("oor_wr_bresp",   32'(resp), 32'h2);
    chk("oor_wr_latency", 32'(lat),  32'd2);
    axi_read(32'h4000, rd, resp, lat);
    chk("oor_rd_rresp",   32'(resp), 32'h2);
    chk("oor_rd_rdata",   rd,        32'h0);
    chk("oor_en_count",   32'(en_cnt - en0), 32'd0);

    // Competing writes and reads, four each
    nw = 0; nr = 0; order = 8'h0;
    s_axi.S_AXI_AWADDR  = 32'h100;
    s_axi.S_AXI_WDATA   = 32'hA000_0000;
    s_axi.S_AXI_WSTRB   = 4'hF;
    s_axi.S_AXI_ARADDR  = 32'h10;
    s_axi.S_AXI_AWVALID = 1'b1;
    s_axi.S_AXI_WVALID  = 1'b1;
    s_axi.S_AXI_ARVALID = 1'b1;
    s_axi.S_AXI_BREADY  = 1'b1;
    s_axi.S_AXI_RREADY  = 1'b1;
    for (int c = 0; c < 200 && (nw < 4 || nr < 4); c++) begin
      #1;
      gw = s_axi.S_AXI_AWREADY && s_axi.S_AXI_WREADY;
      gr = s_axi.S_AXI_ARREADY;
      @(posedge clk); #1;
      if (gw) begin
        order = {order[6:0], 1'b1};
        nw++;
        s_axi.S_AXI_AWADDR = s_axi.S_AXI_AWADDR + 32'd4;
        s_axi.S_AXI_WDATA  = s_axi.S_AXI_WDATA + 32'd1;
        if (nw == 4) begin
          s_axi.S_AXI_AWVALID = 1'b0;
          s_axi.S_AXI_WVALID  = 1'b0;
        end
      end
      if (gr) begin
        order = {order[6:0], 1'b0};
        nr++;
        if (nr == 4) s_axi.S_AXI_ARVALID = 1'b0;
      end
    end
    repeat (4) @(posedge clk);
    #1;
    s_axi.S_AXI_BREADY = 1'b0;
    s_axi.S_AXI_RREADY = 1'b0;
`ifdef AXI_BRAM_CTRL_RR_ARB_EN
    order_exp = 8'b1010_1010;
`else
    order_exp = 8'b1111_0000;
`endif
    chk("arb_writes", 32'(nw), 32'd4);
    chk("arb_reads",  32'(nr), 32'd4);
    chk("arb_order",  32'(order), 32'(order_exp));
    axi_read(32'h104, rd, resp, lat);
    chk("arb_wdata", rd, 32'hA000_0001);

    // Reset while the write response is pending
    axi_write(32'h200, 32'h0000_0055, 4'hF, 1'b0, resp, lat);
    chk("pre_rst_bvalid", 32'(s_axi.S_AXI_BVALID), 32'h1);
    en0 = en_cnt;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_bvalid", 32'(s_axi.S_AXI_BVALID), 32'h0);
    chk("mid_rst_en",     32'(bram_en),            32'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_en_count", 32'(en_cnt - en0), 32'd0);
    chk("post_rst_bvalid",   32'(s_axi.S_AXI_BVALID), 32'h0);
    axi_write(32'h40, 32'hCAFE_F00D, 4'hF, 1'b1, resp, lat);
    axi_read(32'h40, rd, resp, lat);
    chk("post_rst_rdata", rd, 32'hCAFE_F00D);
    chk("post_rst_rd_latency", 32'(lat), 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
